reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Generates the per-domain reset lines that feed downstream flops' async reset
//  inputs. The board reset is asserted asynchronously and released synchronously.
//  Release waits for PLL lock, holds for a fixed count, then staggers release
//  domain-by-domain, and signals ready_o. Also handles software reset requests
//  and loss of lock while running.
// PARAMETERS
//  SYNC_STAGES     2   flops in each synchronizer chain (>=2)
//  HOLD_CYCLES     16  cycles all resets stay asserted after lock (>=1)
//  NUM_DOMAINS     3   number of reset outputs (>=1)
//  STAGGER_CYCLES  4   cycles between successive domain releases (>=1)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            raw board reset, async, active-high
//  pll_locked_i in   1            PLL lock, asynchronous; synchronized internally
//  sw_reset_i   in   1            software reset request, synchronous to clk, level
//  rst_o        out  NUM_DOMAINS  per-domain reset, active-high, registered
//  ready_o      out  1            all domains released, registered
//  state_o      out  3            current FSM state, for debug
// BEHAVIOUR
//  Clock/reset: one clock (clk). Reset is asynchronous, active-high (reset).
//  Reset behaviour:
//   - reset=1 forces these values immediately (no clock needed):
//     rst_o='1, ready_o=0, state=ASSERT, cnt=0, idx=0.
//   - Reset sync chain: preset to 1 and shifts in 0; its output is rst_sync.
//   - Lock sync chain: cleared to 0; its output is lock_sync.
//  FSM states (state_o encoding): ASSERT=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4.
//   ASSERT    : if rst_sync==0, go to WAIT_LOCK.
//   WAIT_LOCK : if lock_sync==1, go to HOLD with cnt=0.
//               sw_reset_i is ignored in this state.
//   HOLD      : increment cnt each cycle.
//               - lock_sync==0: go to WAIT_LOCK.
//               - else sw_reset_i==1: set cnt=0 (restart the hold).
//               - else cnt==HOLD_CYCLES-1 and NUM_DOMAINS==1: go to RUN;
//                 rst_o[0]=0 and ready_o=1 on the same edge.
//               - else cnt==HOLD_CYCLES-1: go to RELEASE; rst_o[0]=0, idx=1, cnt=0.
//   RELEASE   : increment cnt each cycle.
//               - when cnt==STAGGER_CYCLES-1: rst_o[idx]=0, idx++, cnt=0.
//               - if idx was NUM_DOMAINS-1 at that edge: also go to RUN, ready_o=1.
//               - lock_sync==0: all rst_o=1, go to WAIT_LOCK.
//               - sw_reset_i==1: all rst_o=1, go to HOLD with cnt=0.
//   RUN       : lock_sync==0 -> WAIT_LOCK.
//               else sw_reset_i==1 -> HOLD, cnt=0.
//               On either exit: all rst_o=1 and ready_o=0 on that same edge.
//  Priority: async reset > lock loss > sw_reset_i > count terminal.
//  rst_o only falls in index order (0, then 1, ...) and always rises for all
//  domains together. ready_o==1 exactly when state==RUN.
//  rst_o[i] rises in any state other than RELEASE/RUN while the rise conditions
//  above hold; it is never 0 outside those two states.
//  Timing with defaults (lock already high, reset falls before edge 1):
//   - rst_sync falls at edge 2, lock_sync rises at edge 2.
//   - WAIT_LOCK at edge 3; HOLD at edge 4.
//   - rst_o[0] falls at edge 20, rst_o[1] at edge 24.
//   - rst_o[2] falls and ready_o rises at edge 28.
//  Counter width: $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1).
//  Index width:   $clog2(NUM_DOMAINS+1). No wrap is reachable.
//  Reset asserted mid-operation: all outputs return to reset values at once.
//  Parameters outside their legal ranges: elaboration $error.
// STRUCTURE
//  Package rstseq_pkg:
//   - typedef enum logic [2:0] rstseq_state_e {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN}
//   - localparam RSTSEQ_STATE_W = 3
//  Sub-module bit_sync #(STAGES, RESET_VAL):
//   - single-bit synchronizer chain with async reset to RESET_VAL.
//   - instantiated twice: reset chain (RESET_VAL=1, D=0) and lock chain (RESET_VAL=0).
//  FSM, counter and rst_o/ready_o registers all live in reset_sequencer, all
//  async-reset on reset.
// TESTING (defaults unless stated)
//  1 Power-on: reset 1->0 before edge 1, lock=1
//    -> rst_o steps 111->110 (e20) ->100 (e24) ->000 (e28); ready_o=1 at e28.
//  2 Late lock: lock rises at edge 10
//    -> HOLD entered at edge 13; rst_o[0] falls at edge 29.
//  3 sw_reset_i pulse for 1 cycle in RUN
//    -> next edge: rst_o=111, ready_o=0, state=HOLD;
//       rst_o[0] falls 16 edges later.
//  4 Lock drops in RELEASE after rst_o[0] has fallen
//    -> rst_o=111 within SYNC_STAGES+1 edges, state=WAIT_LOCK;
//       full sequence repeats once lock returns.
//  5 reset pulsed asynchronously mid-HOLD and mid-RUN (between clock edges)
//    -> rst_o=111, ready_o=0, state_o=0 before the next edge.
//  6 sw_reset_i held for 5 cycles during HOLD at cnt=10
//    -> cnt stays 0 while held; rst_o[0] falls 16 edges after sw_reset_i drops.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// elaboration-time sizing helpers.
package rstseq_pkg;

   localparam int RSTSEQ_STATE_W = 3;

   typedef enum logic [RSTSEQ_STATE_W-1:0] {
      ASSERT    = 3'd0,
      WAIT_LOCK = 3'd1,
      HOLD      = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } rstseq_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer chain with an asynchronous reset to a chosen value.
module bit_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic arst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   if (STAGES < 2) begin : g_chk_stages
      $error("bit_sync: STAGES must be >= 2");
   end

   // Shift the input through the chain; async reset loads every stage.
   always_ff @(posedge clk or posedge arst_i) begin
      if (arst_i) begin
         chain_q <= {STAGES{RESET_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset generator: asserts all resets asynchronously, then releases
// them after PLL lock, a hold period and a fixed stagger between domains.
module reset_sequencer
   import rstseq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int NUM_DOMAINS    = 3,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pll_locked_i,
   input  logic                      sw_reset_i,
   output logic [NUM_DOMAINS-1:0]    rst_o,
   output logic                      ready_o,
   output logic [RSTSEQ_STATE_W-1:0] state_o
);

   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
   localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("reset_sequencer: SYNC_STAGES must be >= 2");
   end
   if (HOLD_CYCLES < 1) begin : g_chk_hold
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
   end
   if (NUM_DOMAINS < 1) begin : g_chk_dom
      $error("reset_sequencer: NUM_DOMAINS must be >= 1");
   end
   if (STAGGER_CYCLES < 1) begin : g_chk_stag
      $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
   end

   logic rst_sync;
   logic lock_sync;

   rstseq_state_e          state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   ready_q, ready_d;

   // The reset chain gives a synchronous release of the board reset.
   bit_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_rst_sync (
      .clk    (clk),
      .arst_i (reset),
      .d_i    (1'b0),
      .q_o    (rst_sync)
   );

   bit_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_lock_sync (
      .clk    (clk),
      .arst_i (reset),
      .d_i    (pll_locked_i),
      .q_o    (lock_sync)
   );

   // Next-state, counter, domain index and output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      case (state_q)
         ASSERT: begin
            rst_d = '1;
            if (!rst_sync) begin
               state_d = WAIT_LOCK;
            end else begin
               state_d = ASSERT;
            end
         end
         WAIT_LOCK: begin
            rst_d = '1;
            cnt_d = '0;
            idx_d = '0;
            if (lock_sync) begin
               state_d = HOLD;
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         HOLD: begin
            rst_d = '1;
            if (!lock_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (sw_reset_i) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               rst_d[0] = 1'b0;
               cnt_d    = '0;
               idx_d    = IDX_W'(1);
               if (NUM_DOMAINS == 1) begin
                  state_d = RUN;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (!lock_sync) begin
               rst_d   = '1;
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (sw_reset_i) begin
               rst_d   = '1;
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == STAGGER_LAST) begin
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     rst_d[i] = 1'b0;
                  end else begin
                     rst_d[i] = rst_q[i];
                  end
               end
               idx_d = idx_q + IDX_W'(1);
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_sync) begin
               rst_d   = '1;
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (sw_reset_i) begin
               rst_d   = '1;
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            rst_d   = '1;
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
      ready_d = (state_d == RUN);
   end

   // State and output registers, all cleared by the board reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   assign rst_o   = rst_q;
   assign ready_o = ready_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a table of timed vectors, hand sequences for the
// late-lock / async-reset / held sw_reset cases, and random stimulus vs a model.
module tb_reset_sequencer;

   localparam int SYNC  = 2;
   localparam int HOLD  = 16;
   localparam int ND    = 3;
   localparam int STAG  = 4;
   localparam int T_RUN = HOLD + (ND - 1) * STAG;

   logic          clk;
   logic          reset;
   logic          lock;
   logic          sw;
   logic [ND-1:0] rst_o;
   logic          ready_o;
   logic [2:0]    state_o;

   int n_tests;
   int n_fail;
   int edge_no;

   reset_sequencer #(
      .SYNC_STAGES    (SYNC),
      .HOLD_CYCLES    (HOLD),
      .NUM_DOMAINS    (ND),
      .STAGGER_CYCLES (STAG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pll_locked_i (lock),
      .sw_reset_i   (sw),
      .rst_o        (rst_o),
      .ready_o      (ready_o),
      .state_o      (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int            edge_no;
      logic          rst_in;
      logic          lock;
      logic          sw;
      logic [ND-1:0] exp_rst;
      logic          exp_ready;
      logic [2:0]    exp_state;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int e, input logic r, input logic l, input logic s,
                      input logic [ND-1:0] er, input logic ey, input logic [2:0] es);
      vec_t v;
      v.edge_no = e; v.rst_in = r; v.lock = l; v.sw = s;
      v.exp_rst = er; v.exp_ready = ey; v.exp_state = es;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [ND-1:0] er, input logic ey,
                        input logic [2:0] es);
      n_tests++;
      if (rst_o !== er || ready_o !== ey || state_o !== es) begin
         n_fail++;
         $display("FAIL %s: rst_o=%b ready_o=%b state_o=%0d, expected rst_o=%b ready_o=%b state_o=%0d",
                  nm, rst_o, ready_o, state_o, er, ey, es);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic s);
      reset = r;
      lock  = l;
      sw    = s;
      @(posedge clk);
      #2;
      edge_no++;
   endtask

   task automatic goto_edge(input int target, input logic l, input logic s);
      while (edge_no < target) step(1'b0, l, s);
   endtask

   // Reference model: elapsed cycles since the hold (re)started decide everything.
   int   m_mode;   // 0 asserted, 1 waiting for lock, 2 sequencing
   int   m_t;
   int   m_since;
   logic m_hist[$];

   task automatic model_reset();
      m_mode  = 0;
      m_t     = 0;
      m_since = 0;
      m_hist.delete();
   endtask

   task automatic model_step(input logic l, input logic s);
      logic rs;
      logic ls;
      rs = (m_since < SYNC);
      ls = (m_hist.size() >= SYNC) ? m_hist[SYNC-1] : 1'b0;
      if (m_mode == 0) begin
         if (!rs) m_mode = 1;
      end else if (m_mode == 1) begin
         if (ls) begin
            m_mode = 2;
            m_t    = 0;
         end
      end else begin
         if (!ls) m_mode = 1;
         else if (s) m_t = 0;
         else if (m_t < T_RUN) m_t++;
      end
      if (m_since < SYNC) m_since++;
      m_hist.push_front(l);
      if (m_hist.size() > SYNC) void'(m_hist.pop_back());
   endtask

   task automatic model_expect(output logic [ND-1:0] er, output logic ey, output logic [2:0] es);
      for (int i = 0; i < ND; i++) er[i] = !(m_mode == 2 && m_t >= HOLD + i * STAG);
      ey = (m_mode == 2 && m_t >= T_RUN);
      if (m_mode == 0) es = 3'd0;
      else if (m_mode == 1) es = 3'd1;
      else if (m_t < HOLD) es = 3'd2;
      else if (ey) es = 3'd4;
      else es = 3'd3;
   endtask

   initial begin
      logic [ND-1:0] er;
      logic          ey;
      logic [2:0]    es;
      logic          r;

      n_tests = 0;
      n_fail  = 0;
      edge_no = 0;
      reset   = 1'b0;
      lock    = 1'b1;
      sw      = 1'b0;
      #1 reset = 1'b1;
      #1;

      // Power-on, sw_reset pulse in RUN, lock loss in RELEASE and recovery.
      add( 0, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0);
      add( 1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0);
      add( 2, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0);
      add( 3, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd1);
      add( 4, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(19, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(20, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3);
      add(23, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3);
      add(24, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 3'd3);
      add(27, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 3'd3);
      add(28, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'd4);
      add(30, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'd4);
      add(31, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 3'd2);
      add(32, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(46, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(47, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3);
      add(48, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3);
      add(50, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 3'd3);
      add(51, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 3'd1);
      add(53, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd1);
      add(54, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(69, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2);
      add(70, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3);
      add(74, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 3'd3);
      add(77, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 3'd3);
      add(78, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'd4);

      for (int k = 0; k < vecs.size(); k++) begin
         while (edge_no < vecs[k].edge_no) step(vecs[k].rst_in, vecs[k].lock, vecs[k].sw);
         check($sformatf("vec%0d_e%0d", k, vecs[k].edge_no),
               vecs[k].exp_rst, vecs[k].exp_ready, vecs[k].exp_state);
      end

      // Late lock: lock goes high just after edge 10.
      reset = 1'b1;
      lock  = 1'b0;
      #1;
      check("late_lock_reset", 3'b111, 1'b0, 3'd0);
      edge_no = 0;
      goto_edge(10, 1'b0, 1'b0);
      goto_edge(12, 1'b1, 1'b0);
      check("late_lock_e12", 3'b111, 1'b0, 3'd1);
      goto_edge(13, 1'b1, 1'b0);
      check("late_lock_e13", 3'b111, 1'b0, 3'd2);
      goto_edge(28, 1'b1, 1'b0);
      check("late_lock_e28", 3'b111, 1'b0, 3'd2);
      goto_edge(29, 1'b1, 1'b0);
      check("late_lock_e29", 3'b110, 1'b0, 3'd3);

      // Async reset between edges while in HOLD.
      reset = 1'b1;
      #1;
      edge_no = 0;
      goto_edge(8, 1'b1, 1'b0);
      check("hold_before_areset", 3'b111, 1'b0, 3'd2);
      reset = 1'b1;
      #1;
      check("areset_mid_hold", 3'b111, 1'b0, 3'd0);

      // sw_reset held 5 cycles from cnt=10 in HOLD.
      edge_no = 0;
      goto_edge(14, 1'b1, 1'b0);
      check("swhold_e14", 3'b111, 1'b0, 3'd2);
      goto_edge(19, 1'b1, 1'b1);
      check("swhold_e19", 3'b111, 1'b0, 3'd2);
      goto_edge(34, 1'b1, 1'b0);
      check("swhold_e34", 3'b111, 1'b0, 3'd2);
      goto_edge(35, 1'b1, 1'b0);
      check("swhold_e35", 3'b110, 1'b0, 3'd3);
      goto_edge(43, 1'b1, 1'b0);
      check("swhold_run_e43", 3'b000, 1'b1, 3'd4);

      // Async reset between edges while in RUN.
      reset = 1'b1;
      #1;
      check("areset_mid_run", 3'b111, 1'b0, 3'd0);

      // Random stimulus against the model.
      lock = 1'b1;
      sw   = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 59) == 0) lock = ~lock;
         sw    = ($urandom_range(0, 39) == 0);
         reset = r;
         if (r) begin
            #1;
            model_reset();
            model_expect(er, ey, es);
            check($sformatf("rand_areset_c%0d", c), er, ey, es);
         end
         @(posedge clk);
         #2;
         if (reset) model_reset();
         else model_step(lock, sw);
         model_expect(er, ey, es);
         check($sformatf("rand_c%0d", c), er, ey, es);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
